// File: rtl/pc_sequencer_if.sv
// Bus between the ALU/control path and the PC/trap sequencer.
// The sequencer is the slave; whoever drives branch/trap requests is the master.
interface pc_sequencer_if;
  logic        stall_in;
  logic        br_enable;
  logic [31:0] br_target;
  logic [7:0]  exception;
  logic        eret;
  logic [31:0] pc;
  logic [31:0] pc_plus8;
  logic        retire;
  logic [31:0] epc;
  logic [7:0]  cause;
  logic        bd;
  logic        exl;
  logic        trap_taken;
  logic        halted;

  modport master (
    output stall_in, br_enable, br_target, exception, eret,
    input  pc, pc_plus8, retire, epc, cause, bd, exl, trap_taken, halted
  );

  modport slave (
    input  stall_in, br_enable, br_target, exception, eret,
    output pc, pc_plus8, retire, epc, cause, bd, exl, trap_taken, halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter and trap sequencer: owns the architectural PC, branch redirect
// with optional delay slot, trap entry/EPC/cause, eret and the TRAP_STALL watchdog.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_4180,
  parameter bit          DELAY_SLOT  = 1'b0,
  parameter int          STALL_LIMIT = 16,
  parameter logic [7:0]  TRAP_STALL  = 8'hFF
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SLOT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [7:0] STALL_LAST = 8'(STALL_LIMIT - 1);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic [7:0]  r_cause;
  logic        r_bd;
  logic        r_exl;
  logic        r_trap_taken;
  logic [7:0]  r_stall_cnt;
  logic [31:0] r_slot_target;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_epc_nxt;
  logic [7:0]  w_cause_nxt;
  logic        w_bd_nxt;
  logic        w_exl_nxt;
  logic        w_trap_taken_nxt;
  logic [7:0]  w_stall_cnt_nxt;
  logic [31:0] w_slot_target_nxt;
  logic        w_retire;
  logic        w_halted;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_is_stall;
  logic        w_is_trap;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_target   = {bus.br_target[31:2], 2'b00};
  assign w_is_stall = (bus.exception == TRAP_STALL);
  assign w_is_trap  = (bus.exception != 8'h00) && !w_is_stall;

  // State register: all architectural state advances together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_epc         <= 32'h0000_0000;
      r_cause       <= 8'h00;
      r_bd          <= 1'b0;
      r_exl         <= 1'b0;
      r_trap_taken  <= 1'b0;
      r_stall_cnt   <= 8'h00;
      r_slot_target <= 32'h0000_0000;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_epc         <= w_epc_nxt;
      r_cause       <= w_cause_nxt;
      r_bd          <= w_bd_nxt;
      r_exl         <= w_exl_nxt;
      r_trap_taken  <= w_trap_taken_nxt;
      r_stall_cnt   <= w_stall_cnt_nxt;
      r_slot_target <= w_slot_target_nxt;
    end
  end

  // Next-state logic: prioritised events, first match wins.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_epc_nxt         = r_epc;
    w_cause_nxt       = r_cause;
    w_bd_nxt          = r_bd;
    w_exl_nxt         = r_exl;
    w_trap_taken_nxt  = 1'b0;
    w_stall_cnt_nxt   = r_stall_cnt;
    w_slot_target_nxt = r_slot_target;

    if (r_state == ST_HALT) begin
      w_state_nxt = ST_HALT;
    end else if (bus.stall_in) begin
      w_state_nxt = r_state;
    end else if (w_is_trap) begin
      w_stall_cnt_nxt = 8'h00;
      if (r_exl) begin
        // A trap inside the handler cannot be recovered; preserve EPC for debug.
        w_state_nxt = ST_HALT;
      end else begin
        w_state_nxt      = ST_RUN;
        w_exl_nxt        = 1'b1;
        w_cause_nxt      = bus.exception;
        w_trap_taken_nxt = 1'b1;
        w_pc_nxt         = TRAP_VECTOR;
        if (r_state == ST_SLOT) begin
          w_epc_nxt = r_pc - 32'd4;
          w_bd_nxt  = 1'b1;
        end else begin
          w_epc_nxt = r_pc;
          w_bd_nxt  = 1'b0;
        end
      end
    end else if (w_is_stall) begin
      if (r_stall_cnt == STALL_LAST) begin
        w_state_nxt = ST_HALT;
      end else begin
        w_stall_cnt_nxt = r_stall_cnt + 8'd1;
      end
    end else if (bus.eret && r_exl) begin
      w_stall_cnt_nxt = 8'h00;
      w_pc_nxt        = r_epc;
      w_exl_nxt       = 1'b0;
      w_state_nxt     = ST_RUN;
    end else if (bus.br_enable && (r_state == ST_RUN)) begin
      w_stall_cnt_nxt = 8'h00;
      if (DELAY_SLOT) begin
        w_slot_target_nxt = w_target;
        w_pc_nxt          = w_pc_plus4;
        w_state_nxt       = ST_SLOT;
      end else begin
        w_pc_nxt = w_target;
      end
    end else if (r_state == ST_SLOT) begin
      w_stall_cnt_nxt = 8'h00;
      w_pc_nxt        = r_slot_target;
      w_state_nxt     = ST_RUN;
    end else begin
      w_stall_cnt_nxt = 8'h00;
      w_pc_nxt        = w_pc_plus4;
    end
  end

  // Output logic: commit strobe and halt flag.
  always_comb begin
    w_halted = (r_state == ST_HALT);
    if (w_halted || bus.stall_in || w_is_trap || w_is_stall) begin
      w_retire = 1'b0;
    end else begin
      w_retire = 1'b1;
    end
  end

  assign bus.pc         = r_pc;
  assign bus.pc_plus8   = r_pc + 32'd8;
  assign bus.retire     = w_retire;
  assign bus.epc        = r_epc;
  assign bus.cause      = r_cause;
  assign bus.bd         = r_bd;
  assign bus.exl        = r_exl;
  assign bus.trap_taken = r_trap_taken;
  assign bus.halted     = w_halted;

endmodule
